// File: rtl/param_data_memory_if.sv
// Request/response bus for param_data_memory.
// master drives req/we/be/addr/wdata; slave returns ready/rdata/rvalid/err.
interface param_data_memory_if #(
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wdata;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rdata, rvalid, err
  );
endinterface

// File: rtl/param_data_memory.sv
// Byte-enabled word memory, self-clearing after reset, pipelined reads.
// Ports: clk, rst (sync, active-low), bus (slave side of the memory bus).
module param_data_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  param_data_memory_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  logic [AW-1:0]       clr_cnt;
  logic                ready_q;
  logic                werr;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [31:0]         widx;
  logic                in_rng;
  logic [AW-1:0]       idx;
  logic                acc;
  logic                acc_rd;
  logic                acc_wr;

  logic [RD_LAT-1:0]   p_v;
  logic [RD_LAT-1:0]   p_e;
  logic [DATA_W-1:0]   p_d [RD_LAT];

  assign widx   = bus.addr >> OFF;
  assign in_rng = widx < 32'(DEPTH);
  assign idx    = widx[AW-1:0];

  // rst gates acceptance so nothing slips in on a reset edge
  assign acc    = rst & ready_q & bus.req;
  assign acc_rd = acc & ~bus.we;
  assign acc_wr = acc & bus.we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        IDLE: ready_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (acc_wr && in_rng) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) mem[idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
    end
  end

  // Data regs load only behind a valid, so the last stage
  // holds the previous response while rvalid is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_v  <= '0;
      p_e  <= '0;
      werr <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) p_d[i] <= '0;
    end else begin
      p_v[0] <= acc_rd;
      p_e[0] <= acc_rd & ~in_rng;
      werr   <= acc_wr & ~in_rng;
      if (acc_rd) p_d[0] <= in_rng ? mem[idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        p_v[i] <= p_v[i-1];
        p_e[i] <= p_e[i-1];
        if (p_v[i-1]) p_d[i] <= p_d[i-1];
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = p_v[RD_LAT-1];
  assign bus.rdata  = p_d[RD_LAT-1];
  assign bus.err    = p_e[RD_LAT-1] | werr;

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory (DEPTH=16, RD_LAT=2).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_param_data_memory;
  localparam int L = 2;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t rq[$];
  int   wq[$];
  exp_t x;
  int   wc;

  param_data_memory_if #(.DATA_W(32)) bus ();

  param_data_memory #(
    .DATA_W(32),
    .DEPTH (16),
    .RD_LAT(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rvalid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexp_rvalid cyc=%0d got %h required none",
                 cyc, bus.rdata);
      end else begin
        x = rq.pop_front();
        if (bus.rdata !== x.d || bus.err !== x.e || cyc != x.cyc) begin
          errors++;
          $display("FAIL read got d=%h e=%b cyc=%0d required d=%h e=%b cyc=%0d",
                   bus.rdata, bus.err, cyc, x.d, x.e, x.cyc);
        end
      end
    end else if (bus.err) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexp_err cyc=%0d got 1 required 0", cyc);
      end else begin
        wc = wq.pop_front();
        if (cyc != wc) begin
          errors++;
          $display("FAIL werr got cyc=%0d required cyc=%0d", cyc, wc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  task automatic op(input logic w, input logic [3:0] b,
                    input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.be    = b;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d,
                    input logic e);
    exp_t t;
    op(1'b0, 4'h0, a, 32'h0);
    t.d   = d;
    t.e   = e;
    t.cyc = cyc + L;
    rq.push_back(t);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d, input logic oor);
    op(1'b1, b, a, d);
    if (oor) wq.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req = 1'b0;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n), 32'd16);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(rq.size() + wq.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.be    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(bus.ready),  32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    chk("rst_rdata",  bus.rdata,       32'd0);
    rst = 1'b1;
    wait_ready("clear_len");

    for (int i = 0; i < 16; i++) rd(32'(i * 4), 32'h0, 1'b0);
    idle(1);
    drain();

    wr(32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    rd(32'h10, 32'hDEADBEEF, 1'b0);
    wr(32'h10, 4'h2, 32'h0000AA00, 1'b0);
    rd(32'h10, 32'hDEADAAEF, 1'b0);
    rd(32'h13, 32'hDEADAAEF, 1'b0);
    idle(1);
    drain();

    for (int i = 1; i <= 4; i++) wr(32'(i * 4), 4'hF, 32'(i), 1'b0);
    for (int i = 1; i <= 4; i++) rd(32'(i * 4), 32'(i), 1'b0);
    wr(32'h4, 4'h0, 32'hFFFFFFFF, 1'b0);
    rd(32'h4, 32'h1, 1'b0);
    idle(1);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdata_hold", bus.rdata, 32'h1);
    end

    rd(32'h40, 32'h0, 1'b1);
    idle(4);
    wr(32'h40, 4'hF, 32'h12345678, 1'b1);
    idle(3);
    rd(32'h0, 32'h0, 1'b0);
    idle(1);
    drain();

    op(1'b0, 4'h0, 32'h4, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_ready("reclear_len");
    bus.req = 1'b0;
    for (int i = 1; i <= 4; i++) rd(32'(i * 4), 32'h0, 1'b0);
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end
endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4096, number of words; power of two.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous, active-low (rst==0 sampled on clk rising edge resets).
REQ-006 SHALL have port req, input, 1 bit, request valid.
REQ-007 SHALL have port we, input, 1 bit, 1=write, 0=read; qualified by req.
REQ-008 SHALL have port be, input, DATA_W/8 bits, byte enables for writes; bit i covers byte lane i.
REQ-009 SHALL have port addr, input, 32 bits, byte address.
REQ-010 SHALL have port wdata, input, DATA_W bits, write data.
REQ-011 SHALL have port ready, output, 1 bit, block accepts requests.
REQ-012 SHALL have port rdata, output, DATA_W bits, read data.
REQ-013 SHALL have port rvalid, output, 1 bit, rdata valid strobe.
REQ-014 SHALL have port err, output, 1 bit, out-of-range access strobe.

Function
REQ-015 SHALL form word index as addr[31:log2(DATA_W/8)]; low byte-offset bits ignored.
REQ-016 SHALL accept a request on an edge where req==1 and ready==1; requests with ready==0 are dropped, not queued.
REQ-017 SHALL implement states CLEAR and IDLE; CLEAR entered on reset, IDLE entered after the last clear write.
REQ-018 SHALL, in CLEAR, write zero to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, with ready=0.
REQ-019 SHALL go CLEAR->IDLE on the edge that clears word DEPTH-1; ready=1 from the next cycle, i.e. DEPTH cycles after the first non-reset edge.
REQ-020 SHALL, on an accepted write in range, update only byte lanes with be[i]==1 at the accepting edge; be==0 is a legal no-op.
REQ-021 SHALL, on an accepted read, drive rdata with the addressed word and rvalid=1 for exactly one cycle, RD_LAT cycles after the accepting edge.
REQ-022 SHALL be fully pipelined: one read accepted per cycle, responses in order, back-to-back rvalid permitted.
REQ-023 SHALL return newly written data to a read accepted on the edge after a write to the same word (no stale read-after-write).
REQ-024 SHALL hold rdata at its last value while rvalid==0.
REQ-025 SHALL treat word index >= DEPTH as out of range: writes ignored; reads return rdata=0 with rvalid.
REQ-026 SHALL pulse err for one cycle aligned with rvalid for out-of-range reads, and one cycle after acceptance for out-of-range writes.
REQ-027 SHALL keep ready=1 in IDLE; ready never deasserts except through reset.

Reset
REQ-028 SHALL, while rst==0 at an edge, set state=CLEAR, clr_cnt=0, ready=0, rvalid=0, err=0, rdata=0.
REQ-029 SHALL discard all in-flight reads on reset; no rvalid or err emitted for them afterward.
REQ-030 SHALL restart the full clear on a reset asserted mid-CLEAR or mid-operation; all words read 0 after ready returns.

Verification
REQ-031 Reset, DEPTH=16: rst low 2 cycles then high -> ready=0 for 16 cycles, then 1; reads of words 0..15 return 0.
REQ-032 Write addr=0x10, be=0xF, wdata=0xDEADBEEF; next cycle read 0x10, RD_LAT=2 -> rvalid exactly 2 cycles after read acceptance, rdata=0xDEADBEEF.
REQ-033 Word 0x10 holds 0xDEADBEEF; write be=0x2, wdata=0x0000AA00; read -> 0xDEADAAEF; addr=0x13 reads the same word.
REQ-034 Four back-to-back reads of words 1..4 holding 1,2,3,4 -> four consecutive rvalid cycles, data 1,2,3,4 in order.
REQ-035 DEPTH=16, read addr=0x40 -> rvalid=1, rdata=0, err=1 same cycle; write to 0x40 -> err pulse next cycle, memory unchanged.
REQ-036 Read accepted, rst low before rvalid -> no rvalid or err; CLEAR restarts; previously written words read 0 after ready.
